data_mem_responder: RTL and testbench

- Responder end of the core's data-memory interface: accepts requests from the RV32I data port (memory_transaction, mem_write, address, write data, byte_enablers) and returns read_data plus a one-cycle data_ready.
- Replaces the fixed one-cycle data_ready delay register with a real slave: configurable wait states, an internal byte-lane RAM, an MMIO window and bus-error reporting.
- Sits between the core and the data store in the Harvard top level.

---
 rtl/data_mem_if.sv | 21 ++
 rtl/data_mem_responder.sv | 159 +++++++++++++++
 tb/tb_data_mem_responder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - data-memory request/response bundle between core and responder
interface data_mem_if;
  logic        memory_transaction;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [3:0]  byte_enablers;
  logic [31:0] read_data;
  logic        data_ready;
  logic        bus_error;

  modport master (
    output memory_transaction, mem_write, address, data_in, byte_enablers,
    input  read_data, data_ready, bus_error
  );

  modport slave (
    input  memory_transaction, mem_write, address, data_in, byte_enablers,
    output read_data, data_ready, bus_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory slave: wait states, byte-lane RAM, MMIO window, bus errors
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] MMIO_BASE   = 32'h0001_0000
) (
  input  logic        clock,
  input  logic        async_reset,
  data_mem_if.slave   bus,
  output logic        busy,
  output logic [31:0] gpio_out
);
  localparam int unsigned    WCW       = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [32:0]    RAM_BYTES = 33'd4 << ADDR_WIDTH;
  localparam logic [32:0]    MMIO_LO   = {1'b0, MMIO_BASE};
  localparam logic [32:0]    MMIO_HI   = {1'b0, MMIO_BASE} + 33'd15;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [WCW-1:0]   wait_cnt;
  logic             req_write;
  logic [31:0]      req_addr;
  logic [31:0]      req_data;
  logic [3:0]       req_be;
  logic [63:0]      cycle_cnt;
  logic [31:0]      trans_cnt;
  logic [31:0]      mem [0:(1 << ADDR_WIDTH) - 1];

  logic             eff_write;
  logic [31:0]      eff_addr;
  logic [31:0]      eff_data;
  logic [3:0]       eff_be;
  logic             commit;
  logic             ram_hit;
  logic             mmio_hit;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]       mmio_off;
  logic [31:0]      resp_data;

  // With zero wait states the request commits on its own accept edge, so use the live inputs.
  always_comb begin
    if (state == IDLE) begin
      eff_write = bus.mem_write;
      eff_addr  = bus.address;
      eff_data  = bus.data_in;
      eff_be    = bus.byte_enablers;
    end else begin
      eff_write = req_write;
      eff_addr  = req_addr;
      eff_data  = req_data;
      eff_be    = req_be;
    end
  end

  always_comb begin
    commit = 1'b0;
    if (async_reset) begin
      case (state)
        IDLE:    commit = bus.memory_transaction && (WAIT_STATES == 0);
        WAIT:    commit = (wait_cnt == '0);
        default: commit = 1'b0;
      endcase
    end
  end

  assign ram_hit  = ({1'b0, eff_addr} < RAM_BYTES);
  assign mmio_hit = !ram_hit && ({1'b0, eff_addr} >= MMIO_LO) && ({1'b0, eff_addr} <= MMIO_HI);
  assign word_idx = eff_addr[ADDR_WIDTH+1:2];
  assign mmio_off = 2'((eff_addr - MMIO_BASE) >> 2);

  // Response data is the pre-update value, so writes return the old word/register.
  always_comb begin
    resp_data = '0;
    if (ram_hit) begin
      resp_data = mem[word_idx];
    end else if (mmio_hit) begin
      case (mmio_off)
        2'd0:    resp_data = cycle_cnt[31:0];
        2'd1:    resp_data = cycle_cnt[63:32];
        2'd2:    resp_data = gpio_out;
        default: resp_data = trans_cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (commit && eff_write && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (eff_be[i]) mem[word_idx][8*i +: 8] <= eff_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      req_write      <= 1'b0;
      req_addr       <= '0;
      req_data       <= '0;
      req_be         <= '0;
      cycle_cnt      <= '0;
      trans_cnt      <= '0;
      gpio_out       <= '0;
      busy           <= 1'b0;
      bus.read_data  <= '0;
      bus.data_ready <= 1'b0;
      bus.bus_error  <= 1'b0;
    end else begin
      cycle_cnt      <= cycle_cnt + 64'd1;
      bus.data_ready <= 1'b0;
      bus.bus_error  <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.memory_transaction) begin
            req_write <= bus.mem_write;
            req_addr  <= bus.address;
            req_data  <= bus.data_in;
            req_be    <= bus.byte_enablers;
            busy      <= 1'b1;
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= RESP;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (commit) begin
        bus.data_ready <= 1'b1;
        bus.bus_error  <= !(ram_hit || mmio_hit);
        bus.read_data  <= resp_data;
        trans_cnt      <= trans_cnt + 32'd1;
        if (eff_write && mmio_hit && (mmio_off == 2'd2)) begin
          for (int i = 0; i < 4; i++) begin
            if (eff_be[i]) gpio_out[8*i +: 8] <= eff_data[8*i +: 8];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized, model-checked bench for data_mem_responder
module tb_data_mem_responder;
  logic clk  = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  always #5 clk = ~clk;

  data_mem_if bus0();
  data_mem_if bus1();
  logic        busy0, busy1;
  logic [31:0] gpio0, gpio1;

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .MMIO_BASE(32'h0001_0000)) dut0 (
    .clock(clk), .async_reset(rst0), .bus(bus0), .busy(busy0), .gpio_out(gpio0));
  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2), .MMIO_BASE(32'h0001_0000)) dut1 (
    .clock(clk), .async_reset(rst1), .bus(bus1), .busy(busy1), .gpio_out(gpio1));

  longint gclk = 0;
  always @(posedge clk) gclk <= gclk + 1;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem_m [2][1024];
  logic [31:0] gpio_m [2];
  logic [31:0] gpio_new [2];
  logic        gpio_pend [2];
  longint      gpio_edge [2];
  logic [31:0] trans_m [2];
  logic [31:0] last_rd [2];
  longint      rel [2];
  longint      acc [2];
  longint      pend_edge [2];
  logic [31:0] pend_rd [2];
  logic        pend_err [2];

  function automatic int ws(int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic logic get_dr(int d);
    return (d == 0) ? bus0.data_ready : bus1.data_ready;
  endfunction
  function automatic logic get_err(int d);
    return (d == 0) ? bus0.bus_error : bus1.bus_error;
  endfunction
  function automatic logic [31:0] get_rd(int d);
    return (d == 0) ? bus0.read_data : bus1.read_data;
  endfunction
  function automatic logic get_busy(int d);
    return (d == 0) ? busy0 : busy1;
  endfunction
  function automatic logic [31:0] get_gpio(int d);
    return (d == 0) ? gpio0 : gpio1;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(int d, logic tx, logic w, logic [31:0] a, logic [31:0] wd, logic [3:0] be);
    if (d == 0) begin
      bus0.memory_transaction = tx; bus0.mem_write = w; bus0.address = a;
      bus0.data_in = wd; bus0.byte_enablers = be;
    end else begin
      bus1.memory_transaction = tx; bus1.mem_write = w; bus1.address = a;
      bus1.data_in = wd; bus1.byte_enablers = be;
    end
  endtask

  // Decode table of the responder: RAM below 4 KiB, 16-byte MMIO window, everything else errors.
  task automatic model_req(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input longint re,
                           output logic [31:0] rd, output logic err);
    logic [63:0] cyc;
    cyc = 64'(re - rel[d]);
    rd  = '0;
    err = 1'b0;
    if (a < 32'h0000_1000) begin
      rd = mem_m[d][a[11:2]];
      if (w) for (int i = 0; i < 4; i++) if (be[i]) mem_m[d][a[11:2]][8*i +: 8] = wd[8*i +: 8];
    end else if (a >= 32'h0001_0000 && a <= 32'h0001_000F) begin
      case (a[3:2])
        2'd0:    rd = cyc[31:0];
        2'd1:    rd = cyc[63:32];
        2'd2:    rd = gpio_m[d];
        default: rd = trans_m[d];
      endcase
      if (w && a[3:2] == 2'd2) begin
        gpio_new[d] = gpio_m[d];
        for (int i = 0; i < 4; i++) if (be[i]) gpio_new[d][8*i +: 8] = wd[8*i +: 8];
        gpio_pend[d] = 1'b1;
        gpio_edge[d] = re;
      end
    end else begin
      err = 1'b1;
    end
    trans_m[d] = trans_m[d] + 32'd1;
  endtask

  // Called just after a negedge in an IDLE cycle; returns just after a negedge in the next IDLE cycle.
  task automatic req(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input bit keep,
                     output logic [31:0] obs_rd, output logic obs_err, output int obs_cnt,
                     output longint obs_edge, output longint acc_e);
    logic [31:0] erd;
    logic        eerr;
    drive(d, 1'b1, w, a, wd, be);
    acc_e = gclk;
    acc[d] = acc_e;
    model_req(d, w, a, wd, be, acc_e + ws(d), erd, eerr);
    pend_edge[d] = acc_e + ws(d);
    pend_rd[d]   = erd;
    pend_err[d]  = eerr;
    obs_rd = '0; obs_err = 1'b0; obs_cnt = 0; obs_edge = -1;
    @(posedge clk);
    @(negedge clk);
    if (!keep) drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int s = 0; s < ws(d) + 2; s++) begin
      if (s > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (get_dr(d)) begin
        obs_cnt++;
        obs_rd   = get_rd(d);
        obs_err  = get_err(d);
        obs_edge = gclk - 1;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      longint e;
      logic   exp_dr;
      e = gclk - 1;
      exp_dr = (pend_edge[d] == e);
      if (gpio_pend[d] && e >= gpio_edge[d]) begin
        gpio_m[d]    = gpio_new[d];
        gpio_pend[d] = 1'b0;
      end
      if (exp_dr) last_rd[d] = pend_rd[d];
      check($sformatf("data_ready[%0d]@%0d", d, e), get_dr(d), exp_dr);
      check($sformatf("bus_error[%0d]@%0d", d, e), get_err(d), exp_dr && pend_err[d]);
      check($sformatf("read_data[%0d]@%0d", d, e), get_rd(d), last_rd[d]);
      check($sformatf("busy[%0d]@%0d", d, e), get_busy(d), (acc[d] >= 0) && (e >= acc[d]) && (e <= acc[d] + ws(d)));
      check($sformatf("gpio_out[%0d]@%0d", d, e), get_gpio(d), gpio_m[d]);
    end
  end

  initial begin
    logic [31:0] r, c1, c2, prior, a, wd;
    logic        e, w;
    logic [3:0]  be;
    int          n, d;
    longint      ed, ac, ac1, ac2;

    for (int k = 0; k < 2; k++) begin
      gpio_m[k] = '0; gpio_new[k] = '0; gpio_pend[k] = 1'b0; gpio_edge[k] = 0;
      trans_m[k] = '0; last_rd[k] = '0; rel[k] = 0; acc[k] = -10; pend_edge[k] = -10;
      pend_rd[k] = '0; pend_err[k] = 1'b0;
      drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    repeat (3) @(negedge clk);
    check("reset_busy", {busy1, busy0}, 2'b00);
    check("reset_gpio0", gpio0, 32'h0);
    check("reset_gpio1", gpio1, 32'h0);
    check("reset_dr", {bus1.data_ready, bus0.data_ready}, 2'b00);
    check("reset_rd1", bus1.read_data, 32'h0);
    rst0 = 1'b1; rst1 = 1'b1;
    rel[0] = gclk; rel[1] = gclk;

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 1024; i++)
        req(k, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, r, e, n, ed, ac);

    // Directed sequence on the two-wait-state responder; response count tracked in comments.
    req(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, r, e, n, ed, ac);           // 1
    check("rt_write_pulses", n, 1);
    check("rt_latency", 64'(ed - ac), 2);
    req(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, r, e, n, ed, ac);                  // 2
    check("rt_read_data", r, 32'hDEADBEEF);
    check("rt_read_err", e, 1'b0);
    req(1, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, 1'b0, r, e, n, ed, ac);        // 3
    req(1, 1'b0, 32'h12, 32'h0, 4'h0, 1'b0, r, e, n, ed, ac);                  // 4
    check("lane_write", r, 32'hDEADAAEF);
    req(1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0, r, e, n, ed, ac);           // 5
    check("be0_pulses", n, 1);
    req(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, r, e, n, ed, ac);                  // 6
    check("be0_unchanged", r, 32'hDEADAAEF);
    req(1, 1'b0, 32'h8000, 32'h0, 4'h0, 1'b0, r, e, n, ed, ac);                // 7
    check("err_read_data", r, 32'h0);
    check("err_read_flag", e, 1'b1);
    check("err_read_pulses", n, 1);
    req(1, 1'b1, 32'h8000, 32'hFFFFFFFF, 4'hF, 1'b0, r, e, n, ed, ac);         // 8
    check("err_write_flag", e, 1'b1);
    check("err_write_gpio", gpio1, 32'h0);
    req(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, r, e, n, ed, ac);                  // 9
    check("err_write_ram", r, 32'hDEADAAEF);
    for (int i = 0; i < 8; i++)                                                // 10..17
      req(1, 1'b0, 32'($urandom_range(0, 1023) * 4), 32'h0, 4'h0, 1'b0, r, e, n, ed, ac);
    req(1, 1'b1, 32'h10008, 32'h12345678, 4'hF, 1'b0, r, e, n, ed, ac);        // 18
    check("gpio_write", gpio1, 32'h12345678);
    req(1, 1'b1, 32'h10000, 32'hFFFFFFFF, 4'hF, 1'b0, r, e, n, ed, ac);        // 19
    check("ro_write_err", e, 1'b0);
    req(1, 1'b0, 32'h10008, 32'h0, 4'h0, 1'b0, r, e, n, ed, ac);               // 20
    check("gpio_readback", r, 32'h12345678);
    req(1, 1'b0, 32'h1000C, 32'h0, 4'h0, 1'b0, r, e, n, ed, ac);               // 21
    check("trans_count", r, 32'd1044);
    req(1, 1'b0, 32'h10000, 32'h0, 4'h0, 1'b0, c1, e, n, ed, ac1);
    repeat (5) @(negedge clk);
    req(1, 1'b0, 32'h10000, 32'h0, 4'h0, 1'b0, c2, e, n, ed, ac2);
    check("cycle_accept_gap", 64'(ac2 - ac1), 9);
    check("cycle_delta", c2 - c1, 32'd9);

    // Back-to-back on the zero-wait-state responder with memory_transaction held high.
    req(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, r, e, n, ed, ac1);
    check("b2b_first_latency", 64'(ed - ac1), 0);
    req(0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1, r, e, n, ed, ac2);
    check("b2b_spacing1", 64'(ac2 - ac1), 2);
    req(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, r, e, n, ed, ac);
    check("b2b_spacing2", 64'(ac - ac2), 2);
    check("b2b_pulses", n, 1);

    for (int k = 0; k < 400; k++) begin
      d  = int'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0, 1: a = 32'($urandom_range(0, 4095));
        2:    a = 32'h10000 + 32'($urandom_range(0, 15));
        default: begin
          case ($urandom_range(0, 2))
            0:       a = 32'h1000 + 32'($urandom_range(0, 32'hEFFF));
            1:       a = 32'h10010 + 32'($urandom_range(0, 32'hFFFF));
            default: a = $urandom | 32'h8000_0000;
          endcase
        end
      endcase
      req(d, w, a, wd, be, 1'b0, r, e, n, ed, ac);
      check("rand_pulses", n, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of a write's wait window.
    req(1, 1'b1, 32'h10008, 32'hA5A5A5A5, 4'hF, 1'b0, r, e, n, ed, ac);
    check("gpio_before_reset", gpio1, 32'hA5A5A5A5);
    prior = mem_m[1][8];
    drive(1, 1'b1, 1'b1, 32'h20, 32'h55555555, 4'hF);
    @(posedge clk);
    #2;
    rst1 = 1'b0;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    acc[1] = -10; pend_edge[1] = -10; gpio_pend[1] = 1'b0; gpio_m[1] = '0;
    trans_m[1] = '0; last_rd[1] = '0;
    #1;
    check("midreset_busy", busy1, 1'b0);
    check("midreset_gpio", gpio1, 32'h0);
    check("midreset_dr", bus1.data_ready, 1'b0);
    repeat (3) @(negedge clk);
    rst1 = 1'b1;
    rel[1] = gclk;
    req(1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, r, e, n, ed, ac);
    check("midreset_ram_kept", r, prior);
    req(1, 1'b0, 32'h1000C, 32'h0, 4'h0, 1'b0, r, e, n, ed, ac);
    check("midreset_trans", r, 32'd1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
